protocol_sched: RTL and testbench

PROTOCOL_SCHED -- requirements
Module: protocol_sched

---
 rtl/protocol_sched.sv | 119 +++++++++++
 tb/tb_protocol_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_sched.sv
// Round-robin scheduler that hands a single shared protocol engine to one of
// N_REQ requesters at a time, with a per-transaction WAIT timeout.
module protocol_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic             link_busy,
  output logic [N_REQ-1:0] grant,
  output logic             link_start,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] err,
  output logic             busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [N_REQ-1:0] owner_oh;
  logic             owns_link;

  // First set request at or above rr_q, wrapping around, wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[(int'(rr_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_id;
          state_d = GRANT;
        end
      end
      GRANT: state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A falling link_busy wins over a simultaneous timeout.
        if (!link_busy) begin
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        rr_d    = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        tmo_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        tmo_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode only from registered state, so reset clears them at once.
  assign owner_oh   = N_REQ'(1) << owner_q;
  assign owns_link  = (state_q == GRANT) || (state_q == START) ||
                      (state_q == WAIT)  || (state_q == DONE);
  assign grant      = owns_link ? owner_oh : '0;
  assign link_start = (state_q == START);
  assign done       = (state_q == DONE) ? owner_oh : '0;
  assign err        = ((state_q == DONE) && tmo_q) ? owner_oh : '0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_protocol_sched.sv
// Self-checking bench for protocol_sched: a table of transactions feeds a
// scoreboard that is checked on every done pulse, plus hand-written corner cases.
module tb_protocol_sched;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic       link_busy;
  logic [3:0] grant;
  logic       link_start;
  logic [3:0] done;
  logic [3:0] err;
  logic       busy;

  protocol_sched #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .link_busy  (link_busy),
    .grant      (grant),
    .link_start (link_start),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         blen;
    bit         stuck;
    bit         hold;
    logic [3:0] owner;
    logic       err;
    int         gcycles;
  } vec_t;

  typedef struct {
    logic [3:0] owner;
    logic       err;
    int         gcycles;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  int         busy_len = 0;
  int         busy_rem = 0;
  bit         stuck    = 1'b0;

  logic [3:0] prev_grant   = '0;
  logic [3:0] txn_owner    = '0;
  int         gap_cnt      = 0;
  bit         gap_check_en = 1'b0;
  bit         idle_busy    = 1'b0;
  int         grant_len    = 0;
  int         start_cnt    = 0;
  bit         owner_changed = 1'b0;
  int         txn_count    = 0;
  int         done_count   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got no event, expected one within bound", name);
  endtask

  // Tracks each grant window and checks the scoreboard head on every done pulse.
  task automatic monitor();
    exp_t e;
    if (grant != '0) begin
      if (prev_grant == '0) begin
        if (gap_check_en) begin
          checkOutput("idle_gap", gap_cnt, 1);
          checkOutput("busy_in_idle", {31'd0, idle_busy}, 0);
        end
        txn_owner     = grant;
        grant_len     = 0;
        start_cnt     = 0;
        owner_changed = 1'b0;
        txn_count++;
      end
      if (grant != txn_owner) owner_changed = 1'b1;
      grant_len++;
      if (link_start) start_cnt++;
    end else begin
      gap_cnt++;
      if (busy) idle_busy = 1'b1;
    end
    if (done != '0 || err != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=%b err=%b, expected no pulse", done, err);
      end else begin
        e = sb.pop_front();
        checkOutput("done",          done, e.owner);
        checkOutput("err",           err, {3'b000, e.err} == 4'd1 ? e.owner : 4'd0);
        checkOutput("grant_at_done", grant, e.owner);
        checkOutput("grant_cycles",  grant_len, e.gcycles);
        checkOutput("start_pulses",  start_cnt, 1);
        checkOutput("owner_stable",  {31'd0, owner_changed}, 0);
        checkOutput("busy_at_done",  {31'd0, busy}, 1);
      end
      gap_cnt      = 0;
      idle_busy    = 1'b0;
      gap_check_en = 1'b1;
      done_count++;
    end
    prev_grant = grant;
  endtask

  // One cycle: sample outputs, then model the protocol engine's busy level.
  task automatic tick();
    @(negedge clk);
    monitor();
    if (stuck) begin
      link_busy = 1'b1;
    end else if (busy_rem > 0) begin
      link_busy = 1'b1;
      busy_rem--;
    end else begin
      link_busy = 1'b0;
    end
    if (link_start) busy_rem = busy_len;
  endtask

  task automatic waitGrant(input string name);
    int start = txn_count;
    for (int i = 0; i < 20 && txn_count == start; i++) tick();
    if (txn_count == start) failNow(name);
  endtask

  task automatic waitDone(input string name);
    int start = done_count;
    for (int i = 0; i < 40 && done_count == start; i++) tick();
    if (done_count == start) failNow(name);
  endtask

  task automatic pushExp(input logic [3:0] owner, input logic e, input int g);
    exp_t x;
    x.owner   = owner;
    x.err     = e;
    x.gcycles = g;
    sb.push_back(x);
  endtask

  task automatic applyStimulus(input vec_t v);
    req      = v.req;
    busy_len = v.blen;
    stuck    = v.stuck;
    pushExp(v.owner, v.err, v.gcycles);
    waitGrant("grant_timeout");
    if (!v.hold) req = '0;
    waitDone("done_timeout");
  endtask

  initial begin
    // grant cycles = GRANT + START + (blen+1 WAIT) + DONE; a stuck engine gives 16 WAIT cycles
    vecs[0]  = '{4'b1111,  0, 1'b0, 1'b1, 4'b0001, 1'b0,  4};
    vecs[1]  = '{4'b1111,  1, 1'b0, 1'b1, 4'b0010, 1'b0,  5};
    vecs[2]  = '{4'b1111,  2, 1'b0, 1'b1, 4'b0100, 1'b0,  6};
    vecs[3]  = '{4'b1111,  0, 1'b0, 1'b1, 4'b1000, 1'b0,  4};
    vecs[4]  = '{4'b1111,  0, 1'b0, 1'b0, 4'b0001, 1'b0,  4};
    vecs[5]  = '{4'b0010,  3, 1'b0, 1'b0, 4'b0010, 1'b0,  7};
    vecs[6]  = '{4'b0011,  0, 1'b0, 1'b0, 4'b0001, 1'b0,  4};
    vecs[7]  = '{4'b0001,  0, 1'b1, 1'b0, 4'b0001, 1'b1, 19};
    vecs[8]  = '{4'b0011,  0, 1'b0, 1'b0, 4'b0010, 1'b0,  4};
    vecs[9]  = '{4'b0001, 15, 1'b0, 1'b0, 4'b0001, 1'b0, 19};
    vecs[10] = '{4'b0001, 16, 1'b0, 1'b0, 4'b0001, 1'b1, 19};
    vecs[11] = '{4'b1010,  0, 1'b0, 1'b0, 4'b0010, 1'b0,  4};
    vecs[12] = '{4'b1010,  0, 1'b0, 1'b0, 4'b1000, 1'b0,  4};

    rstn      = 1'b0;
    req       = '0;
    link_busy = 1'b0;
    #2;
    checkOutput("reset_grant", grant, 4'b0000);
    checkOutput("reset_outputs", {link_start, done, err, busy}, 10'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // A later request raised during WAIT must not steal the link.
    req      = 4'b0100;
    busy_len = 4;
    pushExp(4'b0100, 1'b0, 8);
    waitGrant("preempt_grant_timeout");
    req = '0;
    tick();
    tick();
    tick();
    req      = 4'b0001;
    busy_len = 0;
    pushExp(4'b0001, 1'b0, 4);
    waitDone("preempt_done_timeout");
    waitGrant("preempt_next_grant_timeout");
    req = '0;
    waitDone("preempt_next_done_timeout");

    // Leave rr_ptr at 3 so a reset that fails to clear it would favour 1000.
    req = 4'b0100;
    pushExp(4'b0100, 1'b0, 4);
    waitGrant("pre_abort_grant_timeout");
    req = '0;
    waitDone("pre_abort_done_timeout");

    req   = 4'b1000;
    stuck = 1'b1;
    waitGrant("abort_grant_timeout");
    req = '0;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checkOutput("midreset_grant", grant, 4'b0000);
    checkOutput("midreset_outputs", {link_start, done, err, busy}, 10'd0);
    stuck        = 1'b0;
    busy_len     = 0;
    req          = 4'b1010;
    gap_check_en = 1'b0;
    tick();
    tick();
    tick();
    pushExp(4'b0010, 1'b0, 4);
    rstn = 1'b1;
    tick();
    checkOutput("first_req_after_reset", grant, 4'b0010);
    req = '0;
    waitDone("post_reset_done_timeout");

    req = 4'b1000;
    pushExp(4'b1000, 1'b0, 4);
    waitGrant("post_reset_1000_grant_timeout");
    req = '0;
    waitDone("post_reset_1000_done_timeout");

    tick();
    tick();
    checkOutput("final_idle", {grant, busy}, 5'd0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
